fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of write requesters, 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: word width, equal to the downstream FIFO width.
REQ-003 SHALL have parameter BURST_LEN, default 4: maximum words per grant, 1..255.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port nrst, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req, input, N_REQ: per-requester "word valid".
REQ-007 SHALL have port data, input, N_REQ x DATA_W packed: per-requester word; index i is in slice i.
REQ-008 SHALL have port ready, output, N_REQ: per-requester "word accepted this cycle".
REQ-009 SHALL have port fifo_full, input, 1: FIFO full flag.
REQ-010 SHALL have port fifo_w_req, output, 1: FIFO write strobe.
REQ-011 SHALL have port fifo_w_data, output, DATA_W: FIFO write data.
REQ-012 SHALL have port grant_id, output, $clog2(N_REQ): current owner index.
REQ-013 SHALL have port busy, output, 1: high when state is GRANT.
REQ-014 SHALL have port burst_cnt, output, 8: words transferred in the current grant.

Function
REQ-015 SHALL implement FSM states IDLE and GRANT; grant_id, last_gnt, burst_cnt and state are registers.
REQ-016 SHALL define transfer as (state==GRANT) & req[grant_id] & ~fifo_full.
REQ-017 SHALL drive fifo_w_req = transfer, fifo_w_data = data[grant_id] and ready[grant_id] = transfer combinationally, with zero latency.
REQ-018 SHALL hold ready low for all non-granted indices, and shall hold every ready low in IDLE.
REQ-019 SHALL never assert fifo_w_req while fifo_full is high, so the FIFO fail flag stays low.
REQ-020 SHALL select winners round-robin: the first set req bit searching upward from last_gnt+1, modulo N_REQ.
REQ-021 IDLE: if any req is set, the next state SHALL be GRANT with grant_id=winner and burst_cnt=0; otherwise the FSM SHALL stay in IDLE.
REQ-022 IDLE to first transfer latency SHALL be exactly 1 cycle.
REQ-023 GRANT: each transfer SHALL increment burst_cnt.
REQ-024 GRANT: a cycle with fifo_full high SHALL stall the grant without counting and without ending it.
REQ-025 GRANT SHALL end on a transfer with burst_cnt==BURST_LEN-1, or on a cycle where req[grant_id]==0.
REQ-026 At grant end, last_gnt SHALL take grant_id, and the winner over the current req SHALL be searched from grant_id+1.
REQ-027 At grant end with a winner, the FSM SHALL stay in GRANT with the new grant_id and burst_cnt=0, giving a 0-cycle switch.
REQ-028 At grant end with no winner, the FSM SHALL go to IDLE.
REQ-029 A sole active requester SHALL be re-granted to itself after BURST_LEN words without a bubble.
REQ-030 A requester whose req is newly set during another grant SHALL wait for that grant to end; no pre-emption.
REQ-031 Data SHALL leave in per-requester order; interleaving between requesters occurs only at grant boundaries.

Reset
REQ-032 On nrst low, the block SHALL asynchronously set state=IDLE, grant_id=0, last_gnt=N_REQ-1, burst_cnt=0.
REQ-033 During reset, ready=0, fifo_w_req=0 and busy=0; fifo_w_data is don't-care.
REQ-034 Reset mid-burst SHALL abort the grant without a partial write in the reset cycle; after release, requester 0 has first priority.

Structure
REQ-035 Package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the burst_cnt width constant (8).
REQ-036 Combinational sub-module rr_pick SHALL take (req mask, start index) and return (found, index); it is instantiated once.

Verification
REQ-037 Reset, then req=4'b0001 continuous, BURST_LEN=4: first write on the 2nd cycle after IDLE, then a write every cycle with grant_id=0, busy=1, and burst_cnt wrapping 0..3.
REQ-038 req=4'b1111 continuous, fifo_full=0: grant_id sequence 0,1,2,3,0, 4 writes each, no idle cycles between grants.
REQ-039 Owner 2, fifo_full high for 3 cycles mid-burst: fifo_w_req=0 and burst_cnt frozen during the stall; the grant still totals 4 words.
REQ-040 Owner 1 drops req after 2 words while req[3]=1: the grant switches to 3 the next cycle and burst_cnt restarts at 0.
REQ-041 nrst pulsed low mid-burst of owner 2: ready and fifo_w_req go low immediately; after release, req=4'b0101 grants 0 first.
REQ-042 Random req/full for 10k cycles with a scoreboard: no write while full, per-requester order preserved, and no requester starved beyond (N_REQ-1)*BURST_LEN transfers.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals around the write arbiter.
// Handshake: requester i offers data slice i while req[i] is high and must hold
// that word until ready[i] is seen high in the same cycle; a word moves only
// when ready[i] is high, and that same cycle fifo_w_req writes it (never while fifo_full).
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  import fifo_arb_pkg::*;

  logic [N_REQ-1:0]          req;
  logic [N_REQ*DATA_W-1:0]   data;
  logic [N_REQ-1:0]          ready;
  logic                      fifo_full;
  logic                      fifo_w_req;
  logic [DATA_W-1:0]         fifo_w_data;
  logic [$clog2(N_REQ)-1:0]  grant_id;
  logic                      busy;
  logic [BURST_CNT_W-1:0]    burst_cnt;

  modport master (
    output req, data, fifo_full,
    input  ready, fifo_w_req, fifo_w_data, grant_id, busy, burst_cnt
  );

  modport slave (
    input  req, data, fifo_full,
    output ready, fifo_w_req, fifo_w_data, grant_id, busy, burst_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set mask bit at or above start, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IDX_W = $clog2(N);

  int               p;
  logic [IDX_W-1:0] pidx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    p     = 0;
    pidx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      pidx = IDX_W'(p);
      if (mask[pidx]) begin
        found = 1'b1;
        idx   = pidx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging N_REQ word streams into one FIFO write port,
// with bounded bursts per grant and zero-cycle owner switches.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          ready,
  input  logic                      fifo_full,
  output logic                      fifo_w_req,
  output logic [DATA_W-1:0]         fifo_w_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [BURST_CNT_W-1:0]    burst_cnt
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [BURST_CNT_W-1:0] CNT_LAST = BURST_CNT_W'(BURST_LEN - 1);

  arb_state_e             state, state_nx;
  logic [IDX_W-1:0]       last_gnt, last_nx, grant_nx;
  logic [BURST_CNT_W-1:0] cnt_nx;
  logic [IDX_W-1:0]       search_base, search_start, win_idx;
  logic                   win_found, transfer, grant_end;

  // In IDLE the search resumes after the previous owner; at grant end, after the current one.
  assign search_base  = (state == IDLE) ? last_gnt : grant_id;
  assign search_start = (search_base == LAST_IDX) ? '0 : search_base + IDX_W'(1);

  rr_pick #(.N(N_REQ)) u_pick (
    .mask  (req),
    .start (search_start),
    .found (win_found),
    .idx   (win_idx)
  );

  assign transfer  = (state == GRANT) && req[grant_id] && !fifo_full;
  assign grant_end = (state == GRANT) &&
                     (!req[grant_id] || (transfer && burst_cnt == CNT_LAST));

  assign fifo_w_req  = transfer;
  assign fifo_w_data = data[grant_id*DATA_W +: DATA_W];
  assign busy        = (state == GRANT);

  always_comb begin
    ready           = '0;
    ready[grant_id] = transfer;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    last_nx  = last_gnt;
    cnt_nx   = burst_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nx = GRANT;
          grant_nx = win_idx;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          last_nx = grant_id;
          cnt_nx  = '0;
          if (win_found) grant_nx = win_idx;
          else           state_nx = IDLE;
        end else if (transfer) begin
          cnt_nx = burst_cnt + BURST_CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      grant_id  <= '0;
      last_gnt  <= LAST_IDX;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      grant_id  <= grant_nx;
      last_gnt  <= last_nx;
      burst_cnt <= cnt_nx;
    end
  end

endmodule
